// File: rtl/comparador_serial_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comparador_defs (package)
//  Description : Shared definitions for the serial equality comparator:
//                FSM state encodings and the slice-index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package comparador_defs;

    // Encoding 2'd3 is unused; the FSM treats it as illegal and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Slice index width: at least one bit, even when there is a single slice.
    function automatic int calc_idxw(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/comparador2bits.sv
`default_nettype none
// ============================================================================
//  Module      : comparador2bits
//  Description : 2-bit equality cell. o_eq is high when both 2-bit inputs
//                are identical.
//  Ports       : i_a, i_b  [1:0] slices to compare
//                o_eq            1 = slices equal
//  Revision    : 1.0 - initial release
// ============================================================================
module comparador2bits (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic       o_eq
);

    assign o_eq = (i_a == i_b);

endmodule
`default_nettype wire

// File: rtl/comparador_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : comparador_serial_ctrl
//  Description : Serial WIDTH-bit equality compare using one shared 2-bit
//                equality cell. Slices are examined LSB first, one per cycle,
//                stopping at the first mismatch.
//  Ports       : clk, rst            clock / synchronous active-high reset
//                start               request, accepted only in IDLE
//                a, b     [WIDTH]    operands, sampled on the accepting edge
//                busy                high while comparing
//                done                one-cycle pulse when the result is valid
//                equal               1 = all slices matched
//                mismatch_idx [IDXW] first mismatching slice (0 when equal)
//  Revision    : 1.0 - initial release
// ============================================================================
module comparador_serial_ctrl
    import comparador_defs::*;
#(
    parameter  int WIDTH  = 8,
    localparam int NSLICE = WIDTH / 2,
    localparam int IDXW   = calc_idxw(NSLICE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic            busy,
    output logic            done,
    output logic            equal,
    output logic [IDXW-1:0] mismatch_idx
);

    localparam logic [IDXW-1:0] c_last_slice = IDXW'(NSLICE - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [WIDTH-1:0]  r_sa;
    logic [WIDTH-1:0]  r_sb;
    logic [IDXW-1:0]   r_cnt;
    logic              r_equal;
    logic [IDXW-1:0]   r_mismatch_idx;
    logic              w_slice_eq;
    logic              w_last_slice;

    // The only compare path: the low slice of each shift register.
    comparador2bits u_cell (
        .i_a  (r_sa[1:0]),
        .i_b  (r_sb[1:0]),
        .o_eq (w_slice_eq)
    );

    assign w_last_slice = (r_cnt == c_last_slice);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                w_next_state = start ? ST_COMPARE : ST_IDLE;
            end
            ST_COMPARE: begin
                if (!w_slice_eq || w_last_slice) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_COMPARE;
                end
            end
            ST_DONE: begin
                // start is deliberately ignored here: no queuing.
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: operand shift registers, slice counter, result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa           <= '0;
            r_sb           <= '0;
            r_cnt          <= '0;
            r_equal        <= 1'b0;
            r_mismatch_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sa           <= a;
                        r_sb           <= b;
                        r_cnt          <= '0;
                        r_equal        <= 1'b0;
                        r_mismatch_idx <= '0;
                    end
                end
                ST_COMPARE: begin
                    if (!w_slice_eq) begin
                        r_equal        <= 1'b0;
                        r_mismatch_idx <= r_cnt;
                    end else if (w_last_slice) begin
                        r_equal        <= 1'b1;
                        r_mismatch_idx <= '0;
                    end else begin
                        r_sa  <= r_sa >> 2;
                        r_sb  <= r_sb >> 2;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // DONE and the illegal encoding hold the results.
                end
            endcase
        end
    end

    // All outputs come straight from registers or a decode of the state register.
    assign busy         = (r_state == ST_COMPARE);
    assign done         = (r_state == ST_DONE);
    assign equal        = r_equal;
    assign mismatch_idx = r_mismatch_idx;

endmodule
`default_nettype wire

// File: doc/comparador_serial_ctrl.md
# comparador_serial_ctrl

- Sequencer that compares two `WIDTH`-bit words for equality using one shared 2-bit equality cell.
- Each cycle it presents one 2-bit slice of each operand to the cell, LSB slice first, and stops at the first mismatch.
- Reports the equal/not-equal result and the index of the first mismatching slice, with a `start`/`busy`/`done` handshake.
- Sits between a register file or test harness and the 2-bit comparator datapath, so wide compares run without widening the cell.

## Interface
- `WIDTH`, default 8: operand width in bits; must be even and ≥ 2. Derived: `NSLICE = WIDTH/2`, `IDXW = max(1, clog2(NSLICE))`.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only while in IDLE.
- `a`  in  WIDTH  operand A; sampled on the accepting edge only.
- `b`  in  WIDTH  operand B; sampled on the accepting edge only.
- `busy`  out  1  high while in COMPARE.
- `done`  out  1  one-cycle pulse when a result becomes valid.
- `equal`  out  1  1 = all slices matched; held until the next accepted start.
- `mismatch_idx`  out  IDXW  first mismatching slice (0 = bits[1:0]); 0 when `equal=1`; held like `equal`.

## Operation
- **States:** IDLE, COMPARE, DONE.
- **IDLE:**
  - If `start=1`, load `a`/`b` into internal shift registers `sa`/`sb`.
  - Clear the slice counter `cnt`, clear `equal` and `mismatch_idx`, and go to COMPARE.
  - If `start=0`, stay in IDLE.
- **COMPARE:** the cell sees `sa[1:0]`, `sb[1:0]`.
  - Mismatch: `equal<=0`, `mismatch_idx<=cnt`, go to DONE.
  - Match and `cnt==NSLICE-1`: `equal<=1`, `mismatch_idx<=0`, go to DONE.
  - Match otherwise: shift `sa`/`sb` right by 2, `cnt<=cnt+1`, stay in COMPARE.
- **DONE:** assert `done` for exactly one cycle, then go to IDLE unconditionally.
- **`start` outside IDLE:** ignored, including the DONE cycle. There is no queuing.
- **Operand changes:** changes on `a`/`b` while not in IDLE have no effect.
- **`cnt` width:** IDXW bits; never wraps, because COMPARE exits at `NSLICE-1`.
- **`WIDTH=2`:** one COMPARE cycle; `mismatch_idx` is always 0.

## Timing
- **Reset:** on any edge with `rst=1`, go to IDLE with `busy=0`, `done=0`, `equal=0`, `mismatch_idx=0`, `cnt=0`, `sa=sb=0`. Reset wins over `start`.
- **Reset mid-operation:** aborts the compare with no `done` pulse; results are cleared.
- **Registered outputs:** all outputs are registered (`busy` is decoded from the state register, not from inputs).
- **Acceptance:** `start` is sampled at edge E0 while in IDLE; `busy=1` from E0 onward.
- **Mismatch at slice i:** DONE is entered at edge E0+i+1, so `done=1` and the result are valid in the cycle after E0+i+1. `busy` falls at that same edge.
- **Full match:** DONE is entered at edge E0+NSLICE. This is the worst-case latency, identical to a mismatch at slice NSLICE-1.
- **Back-to-back:** with `start` held high, the next accept happens on the edge after DONE. Period is (slices compared + 2) cycles.
- **Result stability:** `equal` and `mismatch_idx` are stable from the DONE cycle until the next accepting edge, where both clear.

## Structure
- Shared header/package `comparador_defs`: state encodings `ST_IDLE=2'd0`, `ST_COMPARE=2'd1`, `ST_DONE=2'd2`. Encoding `2'd3` is illegal and recovers to IDLE.
- One sub-module, the existing `comparador2bits` 2-bit equality cell, instantiated once (inputs `sa[1:0]`, `sb[1:0]`). Its output is the only compare path; there is no wide `==` in this block.
- Remainder is in the top level: FSM, shift registers, counter, result registers.

## Test plan
All scenarios use `WIDTH=8`.
- **Full match:** `a=b=8'hA5`, one-cycle `start`.
  - `busy` is high for 4 cycles.
  - `done` pulses in the 5th cycle after the accepting edge, with `equal=1`, `mismatch_idx=0`.
- **Mismatch at slice 0:** `a=8'hA5`, `b=8'hA4`.
  - `busy` is high for 1 cycle.
  - `done` in the next cycle, with `equal=0`, `mismatch_idx=0`.
- **Mismatch at slice 3:** `a=8'h25`, `b=8'hA5`.
  - `done` arrives at the same latency as the full match.
  - `equal=0`, `mismatch_idx=3`.
- **Operand and start changes while busy:** start `a=b=8'h3C`, then drive `a=8'hFF` and pulse `start` while `busy=1`.
  - Result is `equal=1`.
  - Only one `done` pulse occurs.
  - The extra `start` is ignored.
- **Back-to-back with `start` held high:** `a=8'h00`, `b=8'h30`.
  - Each op returns `mismatch_idx=2`.
  - The `done` period is 5 cycles.
  - `equal`/`mismatch_idx` clear on each re-accept.
- **Reset mid-operation:** assert `rst` for 1 cycle during COMPARE of `a=b=8'h55`.
  - No `done` pulse occurs.
  - All outputs read 0 on the next cycle.
  - A fresh `start` completes normally with `equal=1`.
